// File: rtl/usermem_responder_pkg.sv
// Shared constants for the user-memory responder: address map, register bit
// positions and timer state encoding.
package usermem_responder_pkg;

  localparam int unsigned RamDepth = 240;
  localparam logic [7:0]  RamLimit = 8'hEF;

  localparam logic [7:0] AddrGpioOut = 8'hF0;
  localparam logic [7:0] AddrGpioIn  = 8'hF1;
  localparam logic [7:0] AddrReload  = 8'hF2;
  localparam logic [7:0] AddrCount   = 8'hF3;
  localparam logic [7:0] AddrCtrl    = 8'hF4;
  localparam logic [7:0] AddrStatus  = 8'hF5;

  localparam int unsigned CtrlTenBit    = 0;
  localparam int unsigned CtrlIenBit    = 1;
  localparam int unsigned StatusPendBit = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StFire  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/usermem_timer.sv
// Reloading down-counter with a one-cycle FIRE state and a registered
// single-cycle interrupt pulse that follows FIRE.
module usermem_timer
  import usermem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ten,
  input  logic       ien,
  input  logic       force_idle,
  input  logic [7:0] reload,
  output logic [7:0] count,
  output logic       fire,
  output logic       interrupt
);

  timer_state_e state_q;
  logic [7:0]   count_q;
  logic         irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= (state_q == StFire) && ien;
      if (force_idle) begin
        // Disable parks the FSM and keeps COUNT where it stopped.
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (ten && (reload != 8'h00)) begin
              state_q <= StCount;
              count_q <= reload;
            end
          end
          StCount: begin
            if (count_q <= 8'h01) begin
              state_q <= StFire;
              count_q <= 8'h00;
            end else begin
              count_q <= count_q - 8'h01;
            end
          end
          StFire: begin
            count_q <= reload;
            state_q <= (ten && (reload != 8'h00)) ? StCount : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign count     = count_q;
  assign fire      = (state_q == StFire);
  assign interrupt = irq_q;

endmodule

// File: rtl/usermem_responder.sv
// CPU user-memory slave: 240-byte RAM, GPIO, and timer registers behind a
// zero-latency combinational read port.
module usermem_responder
  import usermem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rw,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       interrupt
);

  logic [7:0] ram [RamDepth];
  logic [7:0] gpio_out_q, sync1_q, sync2_q, reload_q;
  logic [1:0] ctrl_q;
  logic       pend_q;
  logic [7:0] count;
  logic       fire;

  logic wr_ram, wr_gpio, wr_reload, wr_ctrl, wr_status, force_idle;

  assign wr_ram     = rw && (address <= RamLimit);
  assign wr_gpio    = rw && (address == AddrGpioOut);
  assign wr_reload  = rw && (address == AddrReload);
  assign wr_ctrl    = rw && (address == AddrCtrl);
  assign wr_status  = rw && (address == AddrStatus);
  assign force_idle = wr_ctrl && !wdata[CtrlTenBit];

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[address] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      reload_q   <= 8'h00;
      ctrl_q     <= 2'b00;
      pend_q     <= 1'b0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (wr_gpio)   gpio_out_q <= wdata;
      if (wr_reload) reload_q   <= wdata;
      if (wr_ctrl)   ctrl_q     <= wdata[1:0];
      // A FIRE in the same cycle as a clear keeps PEND set.
      if (fire) pend_q <= 1'b1;
      else if (wr_status && wdata[StatusPendBit]) pend_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (address <= RamLimit) begin
      rdata = ram[address];
    end else begin
      case (address)
        AddrGpioOut: rdata = gpio_out_q;
        AddrGpioIn:  rdata = sync2_q;
        AddrReload:  rdata = reload_q;
        AddrCount:   rdata = count;
        AddrCtrl:    rdata = {6'b000000, ctrl_q};
        AddrStatus:  rdata = {7'b0000000, pend_q};
        default:     rdata = 8'h00;
      endcase
    end
  end

  usermem_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .ten        (ctrl_q[CtrlTenBit]),
    .ien        (ctrl_q[CtrlIenBit]),
    .force_idle (force_idle),
    .reload     (reload_q),
    .count      (count),
    .fire       (fire),
    .interrupt  (interrupt)
  );

  assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_usermem_responder.sv
// Directed bench for usermem_responder: register/RAM vector table plus
// hand-timed timer, GPIO-sync and reset sequences.
module tb_usermem_responder;
  import usermem_responder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       rw;
  logic [7:0] address, wdata, rdata, gpio_in, gpio_out;
  logic       interrupt;

  int passed = 0;
  int total  = 0;

  usermem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .rw        (rw),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %02h expected %02h", name, act, exp);
    else passed++;
  endtask

  // Drive one bus cycle at the falling edge; check rdata before the commit edge.
  task automatic step(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic chk, input logic [7:0] exp, input string name);
    @(negedge clk);
    rw = w; address = a; wdata = d;
    #1;
    if (chk) check(name, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rw = 1'b0; address = 8'h00; wdata = 8'h00; gpio_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_interrupt", {7'b0, interrupt}, 8'h00);
    step(1'b0, AddrCtrl, 8'h00, 1'b1, 8'h00, "rst_ctrl");

    vecs.push_back('{1'b1, 8'h10, 8'h5A, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'h10, 8'h00, 1'b1, 8'h5A});
    vecs.push_back('{1'b1, 8'hF0, 8'h3C, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF0, 8'h00, 1'b1, 8'h3C});
    vecs.push_back('{1'b1, 8'hF8, 8'hFF, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF8, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'hF1, 8'hFF, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF1, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'hF3, 8'h77, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF3, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'hF2, 8'h12, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF2, 8'h00, 1'b1, 8'h12});
    vecs.push_back('{1'b1, 8'hF4, 8'hFC, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF4, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'hF4, 8'h02, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF4, 8'h00, 1'b1, 8'h02});
    vecs.push_back('{1'b1, 8'hF4, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 8'hEF, 8'hC3, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hEF, 8'h00, 1'b1, 8'hC3});
    vecs.push_back('{1'b0, 8'h10, 8'h00, 1'b1, 8'h5A});
    vecs.push_back('{1'b0, 8'h10, 8'h00, 1'b1, 8'h5A});
    vecs.push_back('{1'b1, 8'hF2, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF2, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'hF5, 8'h01, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 8'hF5, 8'h00, 1'b1, 8'h00});

    foreach (vecs[k]) step(vecs[k].rw, vecs[k].addr, vecs[k].wdata, vecs[k].chk,
                           vecs[k].exp, $sformatf("vec%0d_addr%02h", k, vecs[k].addr));
    check("gpio_out_written", gpio_out, 8'h3C);

    // Reset with a simultaneous GPIO_OUT write: reset must win, RAM must survive.
    @(negedge clk);
    reset = 1'b1; rw = 1'b1; address = AddrGpioOut; wdata = 8'hFF;
    @(negedge clk);
    reset = 1'b0; rw = 1'b0;
    #1;
    check("rst_gpio_out", gpio_out, 8'h00);
    step(1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, "ram_after_reset");
    step(1'b0, AddrGpioOut, 8'h00, 1'b1, 8'h00, "rst_gpio_out_rd");
    step(1'b0, AddrReload, 8'h00, 1'b1, 8'h00, "rst_reload");
    step(1'b0, AddrCount, 8'h00, 1'b1, 8'h00, "rst_count");
    step(1'b0, AddrStatus, 8'h00, 1'b1, 8'h00, "rst_status");

    // GPIO input sync: two-edge latency.
    @(negedge clk);
    gpio_in = 8'hA5; rw = 1'b0; address = AddrGpioIn;
    #1; check("gpio_in_lat0", rdata, 8'h00);
    @(negedge clk); #1; check("gpio_in_lat1", rdata, 8'h00);
    @(negedge clk); #1; check("gpio_in_lat2", rdata, 8'hA5);

    // Periodic timer with IEN: period RELOAD+1 = 4.
    step(1'b1, AddrReload, 8'h03, 1'b0, 8'h00, "");
    step(1'b1, AddrCtrl, 8'h03, 1'b0, 8'h00, "");
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rw = 1'b0; address = AddrCount;
      #1;
      check($sformatf("t4_count_%0d", i), rdata,
            (i == 0) ? 8'h00 : 8'(3 - ((i - 1) % 4)));
      check($sformatf("t4_irq_%0d", i), {7'b0, interrupt},
            ((i >= 5) && ((i - 5) % 4 == 0)) ? 8'h01 : 8'h00);
    end
    step(1'b1, AddrCtrl, 8'h02, 1'b0, 8'h00, "");
    step(1'b0, AddrCount, 8'h00, 1'b1, 8'h02, "disable_holds_count");
    step(1'b0, AddrStatus, 8'h00, 1'b1, 8'h01, "pend_set");
    step(1'b1, AddrStatus, 8'h01, 1'b0, 8'h00, "");
    step(1'b0, AddrStatus, 8'h00, 1'b1, 8'h00, "pend_cleared");
    step(1'b1, AddrCtrl, 8'h03, 1'b0, 8'h00, "");
    step(1'b0, AddrCount, 8'h00, 1'b1, 8'h02, "reenable_wait");
    step(1'b0, AddrCount, 8'h00, 1'b1, 8'h03, "reenable_reload");
    step(1'b1, AddrCtrl, 8'h00, 1'b0, 8'h00, "");

    // IEN=0: PEND sets, interrupt never asserts.
    step(1'b1, AddrReload, 8'h02, 1'b0, 8'h00, "");
    step(1'b1, AddrCtrl, 8'h01, 1'b0, 8'h00, "");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rw = 1'b0; address = AddrStatus;
      #1;
      check($sformatf("noien_irq_%0d", i), {7'b0, interrupt}, 8'h00);
      check($sformatf("noien_pend_%0d", i), rdata, (i >= 4) ? 8'h01 : 8'h00);
    end

    // Clear coinciding with FIRE: set wins.
    step(1'b1, AddrStatus, 8'h01, 1'b0, 8'h00, "");
    check("in_fire_state", 8'(dut.u_timer.state_q), 8'(StFire));
    step(1'b0, AddrStatus, 8'h00, 1'b1, 8'h01, "clear_vs_fire");
    step(1'b1, AddrStatus, 8'h01, 1'b0, 8'h00, "");
    step(1'b0, AddrStatus, 8'h00, 1'b1, 8'h00, "clear_outside_fire");

    // RELOAD change mid-count applies only at the next reload.
    step(1'b1, AddrReload, 8'h05, 1'b0, 8'h00, "");
    step(1'b1, AddrCtrl, 8'h03, 1'b0, 8'h00, "");
    step(1'b0, AddrCount, 8'h00, 1'b1, 8'h00, "old_reload_fire");

    // Reset while counting at 0x05 aborts with no later interrupt.
    @(negedge clk);
    rw = 1'b0; address = AddrCount; reset = 1'b1;
    #1;
    check("new_reload_count", rdata, 8'h05);
    check("irq_before_reset", {7'b0, interrupt}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("post_rst_irq_%0d", i), {7'b0, interrupt}, 8'h00);
      check($sformatf("post_rst_count_%0d", i), rdata, 8'h00);
      @(negedge clk);
    end
    check("post_rst_state", 8'(dut.u_timer.state_q), 8'(StIdle));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
